// File: rtl/parity_pkg.sv
// Shared constants for the parity serialiser/deserialiser: parity mode values
// and the TX frame FSM state encoding.
package parity_pkg;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } tx_state_t;

endpackage

// File: rtl/parity_serdes_gen_chk_rx.sv
// Receive side: collects DATA_W data bits (LSB first) plus one parity bit,
// checks parity against the mode captured with data bit 0, counts errors.
module parity_rx_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] rx_word,
  output logic              rx_word_valid,
  output logic              rx_parity_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              mode_q;
  logic              frame_err;

  // A clean frame has ^data ^ parity equal to the mode (1 for odd, 0 for even).
  assign frame_err = (^sh_q ^ rx_bit) != mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      sh_q          <= '0;
      mode_q        <= MODE_EVEN;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      err_count     <= '0;
    end else begin
      rx_word_valid <= 1'b0;
      if (rx_valid) begin
        if (cnt_q == CW'(DATA_W)) begin
          cnt_q         <= '0;
          rx_word       <= sh_q;
          rx_word_valid <= 1'b1;
          rx_parity_err <= frame_err;
          if (frame_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
          end
        end else begin
          sh_q  <= {rx_bit, sh_q[DATA_W-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == '0) begin
            mode_q <= odd_mode;
          end
        end
      end
    end
  end

endmodule

// File: rtl/parity_serdes_gen_chk.sv
// Parity frame generator/checker: serialises a word LSB first plus a parity
// bit on TX, and deserialises/checks the same frame format on RX.
module parity_serdes_gen_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] rx_word,
  output logic              rx_word_valid,
  output logic              rx_parity_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        data_q <= in_data;
        par_q  <= (^in_data) ^ odd_mode;
      end
    end
  end

  // Handshake: a word transfers on any rising edge where in_valid && in_ready;
  // in_valid may be held high across frames. in_ready is high in IDLE and in
  // the parity cycle, so a word taken in the parity cycle starts gaplessly.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    in_ready = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_bit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_bit   = data_q[idx_q];
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DATA_W - 1)) begin
          state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        in_ready = 1'b1;
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_bit   = par_q;
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  parity_rx_checker #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .odd_mode     (odd_mode),
    .rx_bit       (rx_bit),
    .rx_valid     (rx_valid),
    .rx_word      (rx_word),
    .rx_word_valid(rx_word_valid),
    .rx_parity_err(rx_parity_err),
    .err_count    (err_count)
  );

endmodule

// File: doc/parity_serdes_gen_chk.md
Name: parity_serdes_gen_chk

Overview:
- Parametrised, clocked successor to the team's 4-bit combinational odd-parity generator.
- TX path: accepts a DATA_W-bit word over a valid/ready handshake and serialises it LSB first, followed by one parity bit.
- RX path: deserialises the same frame format, checks the parity bit and keeps a saturating error count.
- Parity mode (odd or even) is selected per frame. The block sits between parallel datapath logic and a 1-bit serial link or loopback.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..32).
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- odd_mode  in  1  1 = odd parity (total ones in data+parity is odd), 0 = even parity.
- in_data  in  DATA_W  parallel word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- tx_bit  out  1  serial output bit.
- tx_valid  out  1  tx_bit is valid.
- tx_last  out  1  tx_bit is the parity bit (last bit of the frame).
- rx_bit  in  1  serial input bit.
- rx_valid  in  1  rx_bit is valid; gaps between valid bits are allowed.
- rx_word  out  DATA_W  last received data word.
- rx_word_valid  out  1  one-cycle pulse when a received frame completes.
- rx_parity_err  out  1  parity result of the frame flagged by rx_word_valid.
- err_count  out  CNT_W  saturating count of RX parity errors.

Behaviour:
- Reset: all registered outputs are 0 (tx_bit, tx_valid, tx_last, rx_word, rx_word_valid, rx_parity_err, err_count). in_ready is 1 one cycle after rst deasserts. Reset asserted mid-frame aborts both the TX and RX frame with no partial outputs.
- TX FSM states: IDLE, DATA, PARITY.
  - IDLE: in_ready=1. An accept (in_valid&in_ready) in cycle N latches in_data and odd_mode, computes parity = ^in_data ^ odd_mode, then goes to DATA.
  - DATA: tx_valid=1 and tx_bit = data[bit_idx]. Bit index runs 0..DATA_W-1, one bit per cycle, so the data bits occupy cycles N+1..N+DATA_W. On the last data bit the FSM goes to PARITY.
  - PARITY (cycle N+DATA_W+1): tx_valid=1, tx_last=1, tx_bit=parity, in_ready=1.
    - If a word is accepted in this cycle, go to DATA and emit its bit 0 in the next cycle, giving gapless back-to-back frames.
    - Otherwise go to IDLE.
  - There is no TX backpressure; once a frame starts, tx_valid is continuous for DATA_W+1 cycles.
  - odd_mode and in_data changes mid-frame have no effect on the frame in progress.
- RX:
  - The bit counter advances only on rx_valid. Data bits are shifted in LSB first; odd_mode is sampled with data bit 0.
  - On the (DATA_W+1)th valid bit (the parity bit) in cycle M:
    - in cycle M+1, rx_word_valid=1 for one cycle;
    - rx_word holds the data;
    - rx_parity_err = (^data ^ parity_bit) != odd_mode.
  - rx_word and rx_parity_err hold their values until the next frame completes.
  - err_count increments in cycle M+1 when rx_parity_err=1 and stays at 2^CNT_W-1 once reached (saturates, no wrap).
  - A new frame's bit 0 may arrive in cycle M+1.
- TX and RX are independent and may run simultaneously.

Decomposition:
- Shared package parity_pkg holds:
  - localparams MODE_EVEN=1'b0 and MODE_ODD=1'b1;
  - TX state encodings ST_IDLE, ST_DATA, ST_PARITY.
- One natural sub-module is parity_rx_checker: RX shift register, bit counter, parity check and saturating err_count.
- The TX FSM lives in the top module.

Test Plan:
- DATA_W=8, even: in_data=8'hA5 accepted in cycle 0 → tx_bit over cycles 1..8 is 1,0,1,0,0,1,0,1; cycle 9 gives parity 0 with tx_last=1; in_ready=0 in cycles 1..8.
- Same word with odd_mode=1 → parity bit 1. Word 8'h00 in odd mode → parity 1; in even mode → parity 0.
- Loopback tx_bit→rx_bit, tx_valid→rx_valid, words 8'h3C, 8'hFF, 8'h01 back-to-back (in_valid held high) → frames with no idle cycles; rx_word_valid pulses with rx_word matching each word; rx_parity_err=0; err_count=0.
- Error injection: invert the parity bit on the 2nd frame → rx_parity_err=1 for that frame only; err_count=1. With CNT_W=2 and 5 bad frames, err_count stops at 3.
- RX gaps: drive rx_valid=0 for 3 cycles between every bit of 8'h96 → rx_word=8'h96 is correct and the pulse comes one cycle after the parity bit.
- Assert rst at TX data bit 4 and mid RX frame → next cycle all outputs are 0, in_ready=1; a new frame then transmits and receives correctly.
